// File: rtl/riscv_irq_arbiter.sv
// Interrupt arbiter: masks and prioritises up to 32 lines (id 0 highest) and presents one
// held request with its secure attribute to the core until it is acknowledged or withdrawn.
module riscv_irq_arbiter #(
    parameter int unsigned NUM_IRQ   = 32,
    parameter logic [31:0] EDGE_MASK = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_lines_i,
    input  logic               mask_we_i,
    input  logic [31:0]        mask_wdata_i,
    input  logic               sec_we_i,
    input  logic [31:0]        sec_wdata_i,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_ack_id_i,
    output logic               irq_o,
    output logic [4:0]         irq_id_o,
    output logic               irq_sec_o,
    output logic [31:0]        pending_o,
    output logic [31:0]        mask_o
);

    localparam logic [31:0] VALID_MASK = 32'((64'd1 << NUM_IRQ) - 64'd1);
    localparam logic [31:0] EDGE_VALID = EDGE_MASK & VALID_MASK;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] secure_q, secure_d;
    logic [31:0] hist_q, hist_d;
    logic [31:0] pending_q, pending_d;
    logic [4:0]  id_q, id_d;
    logic        sec_q, sec_d;

    logic [31:0] lines_ext;
    logic [31:0] eligible;
    logic [31:0] ack_clr;
    logic [4:0]  win_id;
    logic        any_elig;
    logic        ack_hit;

    always_comb begin
        lines_ext                = '0;
        lines_ext[NUM_IRQ-1:0]   = irq_lines_i;
    end

    always_comb begin
        mask_d   = mask_we_i ? (mask_wdata_i & VALID_MASK) : mask_q;
        secure_d = sec_we_i  ? (sec_wdata_i  & VALID_MASK) : secure_q;
        hist_d   = lines_ext;
    end

    // Edge lines: a new rising edge beats a same-cycle ack clear. Level lines just follow the input.
    always_comb begin
        pending_d = (((lines_ext & ~hist_q) | (pending_q & ~ack_clr)) & EDGE_VALID)
                  | (lines_ext & ~EDGE_VALID);
        pending_d = pending_d & VALID_MASK;
    end

    assign eligible = pending_q & mask_q;
    assign any_elig = |eligible;
    assign ack_hit  = irq_ack_i && (irq_ack_id_i == id_q);

    // Scan downwards so the lowest eligible index is the last one written.
    always_comb begin
        win_id = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = 5'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        sec_d   = sec_q;
        ack_clr = '0;
        irq_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    id_d    = win_id;
                    sec_d   = secure_q[win_id];
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                irq_o = 1'b1;
                if (ack_hit) begin
                    ack_clr[id_q] = EDGE_VALID[id_q];
                    state_d       = ST_GAP;
                end else if (!eligible[id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                sec_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            secure_q  <= '0;
            hist_q    <= '0;
            pending_q <= '0;
            id_q      <= '0;
            sec_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            secure_q  <= secure_d;
            hist_q    <= hist_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            sec_q     <= sec_d;
        end
    end

    assign irq_id_o  = id_q;
    assign irq_sec_o = sec_q;
    assign pending_o = pending_q;
    assign mask_o    = mask_q;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Bench for riscv_irq_arbiter: directed scenarios followed by random traffic, all checked
// against a cycle-level behavioural model of pending/mask/request behaviour.
module tb_riscv_irq_arbiter;

    localparam logic [31:0] EDGE = 32'h0F00_1288;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] irq_lines = '0;
    logic        mask_we = 1'b0;
    logic [31:0] mask_wdata = '0;
    logic        sec_we = 1'b0;
    logic [31:0] sec_wdata = '0;
    logic        ack = 1'b0;
    logic [4:0]  ack_id = '0;
    logic        irq_o;
    logic [4:0]  irq_id_o;
    logic        irq_sec_o;
    logic [31:0] pending_o;
    logic [31:0] mask_o;

    int total = 0;
    int bad = 0;

    logic [31:0] m_pend, m_mask, m_secreg, m_hist;
    logic        m_req, m_cool, m_sec;
    logic [4:0]  m_id;

    riscv_irq_arbiter #(
        .NUM_IRQ   (32),
        .EDGE_MASK (EDGE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_lines_i  (irq_lines),
        .mask_we_i    (mask_we),
        .mask_wdata_i (mask_wdata),
        .sec_we_i     (sec_we),
        .sec_wdata_i  (sec_wdata),
        .irq_ack_i    (ack),
        .irq_ack_id_i (ack_id),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id_o),
        .irq_sec_o    (irq_sec_o),
        .pending_o    (pending_o),
        .mask_o       (mask_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend   = '0;
        m_mask   = '0;
        m_secreg = '0;
        m_hist   = '0;
        m_req    = 1'b0;
        m_cool   = 1'b0;
        m_sec    = 1'b0;
        m_id     = '0;
    endtask

    // One clock of the reference behaviour, evaluated from the inputs held across the edge.
    task automatic model_step();
        logic [31:0] elig, low, pend_n;
        logic        ack_ok;
        elig   = m_pend & m_mask;
        ack_ok = m_req && ack && (ack_id == m_id);
        for (int i = 0; i < 32; i++) begin
            if (EDGE[i]) begin
                if (irq_lines[i] && !m_hist[i])
                    pend_n[i] = 1'b1;
                else if (ack_ok && (int'(m_id) == i))
                    pend_n[i] = 1'b0;
                else
                    pend_n[i] = m_pend[i];
            end else begin
                pend_n[i] = irq_lines[i];
            end
        end
        if (m_cool) begin
            m_cool = 1'b0;
            m_sec  = 1'b0;
        end else if (m_req) begin
            if (ack_ok) begin
                m_req  = 1'b0;
                m_cool = 1'b1;
            end else if (!elig[m_id]) begin
                m_req = 1'b0;
            end
        end else if (elig != 0) begin
            low   = elig & (~elig + 32'd1);
            m_id  = 5'($clog2(low));
            m_sec = m_secreg[m_id];
            m_req = 1'b1;
        end
        m_pend = pend_n;
        m_hist = irq_lines;
        if (mask_we) m_mask = mask_wdata;
        if (sec_we) m_secreg = sec_wdata;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("irq_o", 32'(irq_o), 32'(m_req));
        chk("pending_o", pending_o, m_pend);
        chk("mask_o", mask_o, m_mask);
        chk("irq_id_o", 32'(irq_id_o), 32'(m_id));
        if (m_req) chk("irq_sec_o", 32'(irq_sec_o), 32'(m_sec));
        mask_we = 1'b0;
        sec_we  = 1'b0;
        ack     = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_id", 32'(irq_id_o), 32'd0);
        chk("rst_sec", 32'(irq_sec_o), 32'd0);
        chk("rst_pend", pending_o, 32'd0);
        chk("rst_mask", mask_o, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // level line with mask 0: pending follows, no request
        irq_lines[5] = 1'b1;
        tick();
        tick();
        chk("lvl_masked_pend", 32'(pending_o[5]), 32'd1);
        chk("lvl_masked_irq", 32'(irq_o), 32'd0);
        irq_lines = '0;
        tick();

        mask_we = 1'b1; mask_wdata = 32'hFFFF_FFFF;
        sec_we  = 1'b1; sec_wdata  = 32'h0000_0004;
        tick();
        chk("mask_visible", mask_o, 32'hFFFF_FFFF);
        tick();

        // edge line 7 pulse
        irq_lines[7] = 1'b1;
        tick();
        chk("e7_pend", 32'(pending_o[7]), 32'd1);
        chk("e7_irq_early", 32'(irq_o), 32'd0);
        irq_lines[7] = 1'b0;
        tick();
        chk("e7_irq", 32'(irq_o), 32'd1);
        chk("e7_id", 32'(irq_id_o), 32'd7);
        tick();
        tick();
        ack = 1'b1; ack_id = 5'd7;
        tick();
        chk("e7_ack_irq", 32'(irq_o), 32'd0);
        chk("e7_ack_pend", 32'(pending_o[7]), 32'd0);
        tick();
        tick();

        // lines 3 and 12 together, then back-to-back
        irq_lines[3] = 1'b1; irq_lines[12] = 1'b1;
        tick();
        tick();
        chk("p3_id", 32'(irq_id_o), 32'd3);
        ack = 1'b1; ack_id = 5'd3;
        tick();
        chk("p3_gap", 32'(irq_o), 32'd0);
        tick();
        chk("p3_idle", 32'(irq_o), 32'd0);
        tick();
        chk("p12_irq", 32'(irq_o), 32'd1);
        chk("p12_id", 32'(irq_id_o), 32'd12);
        ack = 1'b1; ack_id = 5'd12;
        irq_lines = '0;
        tick();
        tick();
        tick();

        // level line 5 withdraws by dropping, then by mask
        irq_lines[5] = 1'b1;
        tick();
        tick();
        chk("l5_id", 32'(irq_id_o), 32'd5);
        irq_lines[5] = 1'b0;
        tick();
        chk("l5_hold", 32'(irq_o), 32'd1);
        tick();
        chk("l5_withdraw", 32'(irq_o), 32'd0);
        irq_lines[5] = 1'b1;
        tick();
        tick();
        chk("l5b_irq", 32'(irq_o), 32'd1);
        mask_we = 1'b1; mask_wdata = 32'hFFFF_FFDF;
        tick();
        chk("l5b_hold", 32'(irq_o), 32'd1);
        tick();
        chk("l5b_masked", 32'(irq_o), 32'd0);
        irq_lines[5] = 1'b0;
        mask_we = 1'b1; mask_wdata = 32'hFFFF_FFFF;
        tick();
        tick();

        // edge line 9 re-rises in the ack cycle
        irq_lines[9] = 1'b1;
        tick();
        irq_lines[9] = 1'b0;
        tick();
        tick();
        chk("e9_id", 32'(irq_id_o), 32'd9);
        irq_lines[9] = 1'b1;
        ack = 1'b1; ack_id = 5'd9;
        tick();
        chk("e9_pend_kept", 32'(pending_o[9]), 32'd1);
        chk("e9_gap", 32'(irq_o), 32'd0);
        irq_lines[9] = 1'b0;
        tick();
        tick();
        chk("e9_repr", 32'(irq_o), 32'd1);
        chk("e9_repr_id", 32'(irq_id_o), 32'd9);
        ack = 1'b1; ack_id = 5'd9;
        tick();
        tick();
        tick();

        // wrong-id ack ignored, secure attribute, async reset mid-request
        irq_lines[2] = 1'b1;
        tick();
        tick();
        ack = 1'b1; ack_id = 5'd4;
        tick();
        chk("wrong_ack_irq", 32'(irq_o), 32'd1);
        chk("wrong_ack_id", 32'(irq_id_o), 32'd2);
        chk("sec2", 32'(irq_sec_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_irq", 32'(irq_o), 32'd0);
        chk("async_rst_pend", pending_o, 32'd0);
        model_reset();
        irq_lines = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mask_we = 1'b1; mask_wdata = 32'hFFFF_FFFF;
        tick();

        // random traffic
        for (int c = 0; c < 600; c++) begin
            irq_lines = irq_lines ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(15) == 0) begin
                mask_we = 1'b1;
                mask_wdata = $urandom | $urandom;
            end
            if ($urandom_range(15) == 0) begin
                sec_we = 1'b1;
                sec_wdata = $urandom;
            end
            if (m_req && ($urandom_range(2) == 0)) begin
                ack = 1'b1;
                ack_id = ($urandom_range(3) != 0) ? m_id : 5'($urandom_range(31));
            end else if ($urandom_range(15) == 0) begin
                ack = 1'b1;
                ack_id = 5'($urandom_range(31));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
